// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter for the shared instruction/data memory port.
// Adds programmable wait states, flags misaligned accesses and stalls the core while M0 waits.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_done,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_done,
  output logic              m1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_stall
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_q, last_d;   // 1 = M1 held the last grant
  logic              win_q, win_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              m0_done_q, m0_done_d;
  logic              m1_done_q, m1_done_d;
  logic              m0_err_q, m0_err_d;
  logic              m1_err_q, m1_err_d;

  logic              grant;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_mis;

  always_comb begin
    // On a tie the master that did not win last time is served.
    grant     = (m0_req & m1_req) ? ~last_q : m1_req;
    sel_we    = grant ? m1_we    : m0_we;
    sel_addr  = grant ? m1_addr  : m0_addr;
    sel_wdata = grant ? m1_wdata : m0_wdata;
    sel_mis   = (sel_addr[1:0] != 2'b00);

    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    win_d       = win_q;
    we_d        = we_q;
    err_d       = err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_re_d    = mem_re_q;
    mem_we_d    = mem_we_q;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    m0_done_d   = 1'b0;
    m1_done_d   = 1'b0;
    m0_err_d    = 1'b0;
    m1_err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0_req | m1_req) begin
          win_d       = grant;
          last_d      = grant;
          we_d        = sel_we;
          err_d       = sel_mis;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          cnt_d       = 4'(WAIT_CYC);
          mem_re_d    = ~sel_we & ~sel_mis;
          mem_we_d    = sel_we & ~sel_mis;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          mem_re_d = 1'b0;
          mem_we_d = 1'b0;
          if (~we_q & ~err_q) begin
            if (win_q) m1_rdata_d = mem_rdata;
            else       m0_rdata_d = mem_rdata;
          end
          m0_done_d = ~win_q;
          m1_done_d = win_q;
          m0_err_d  = ~win_q & err_q;
          m1_err_d  = win_q & err_q;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      last_q      <= 1'b1;
      win_q       <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      m0_done_q   <= 1'b0;
      m1_done_q   <= 1'b0;
      m0_err_q    <= 1'b0;
      m1_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      win_q       <= win_d;
      we_q        <= we_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      m0_done_q   <= m0_done_d;
      m1_done_q   <= m1_done_d;
      m0_err_q    <= m0_err_d;
      m1_err_q    <= m1_err_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign m0_done   = m0_done_q;
  assign m1_done   = m1_done_q;
  assign m0_err    = m0_err_q;
  assign m1_err    = m1_err_q;
  assign cpu_stall = m0_req & ~m0_done_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with one wait state, one with none.
module tb_mem_port_arbiter;
  logic clk, rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        a_m0_req, a_m0_we, a_m1_req, a_m1_we;
  logic [31:0] a_m0_addr, a_m0_wdata, a_m1_addr, a_m1_wdata;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_m0_done, a_m0_err, a_m1_done, a_m1_err, a_mem_re, a_mem_we, a_cpu_stall;

  logic        b_m0_req, b_m0_we, b_m1_req, b_m1_we;
  logic [31:0] b_m0_addr, b_m0_wdata, b_m1_addr, b_m1_wdata;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_m0_done, b_m0_err, b_m1_done, b_m1_err, b_mem_re, b_mem_we, b_cpu_stall;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYC(1)) u_a (
    .clk(clk), .rst(rst),
    .m0_req(a_m0_req), .m0_we(a_m0_we), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata),
    .m0_rdata(a_m0_rdata), .m0_done(a_m0_done), .m0_err(a_m0_err),
    .m1_req(a_m1_req), .m1_we(a_m1_we), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata),
    .m1_rdata(a_m1_rdata), .m1_done(a_m1_done), .m1_err(a_m1_err),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_re(a_mem_re), .mem_we(a_mem_we),
    .mem_rdata(a_mem_rdata), .cpu_stall(a_cpu_stall)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYC(0)) u_b (
    .clk(clk), .rst(rst),
    .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
    .m0_rdata(b_m0_rdata), .m0_done(b_m0_done), .m0_err(b_m0_err),
    .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
    .m1_rdata(b_m1_rdata), .m1_done(b_m1_done), .m1_err(b_m1_err),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_re(b_mem_re), .mem_we(b_mem_we),
    .mem_rdata(b_mem_rdata), .cpu_stall(b_cpu_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_acc(input logic m, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, output int ticks, output int re_n,
                         output int we_n, output logic err, output logic done_seen);
    ticks = 0; re_n = 0; we_n = 0; err = 1'b0; done_seen = 1'b0;
    if (m) begin
      a_m1_req = 1'b1; a_m1_we = we; a_m1_addr = addr; a_m1_wdata = wd;
    end else begin
      a_m0_req = 1'b1; a_m0_we = we; a_m0_addr = addr; a_m0_wdata = wd;
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      ticks++;
      re_n += int'(a_mem_re);
      we_n += int'(a_mem_we);
      if (m ? a_m1_done : a_m0_done) begin
        err = m ? a_m1_err : a_m0_err;
        done_seen = 1'b1;
        break;
      end
    end
    a_m0_req = 1'b0;
    a_m1_req = 1'b0;
    tick();
  endtask

  int   ticks, re_n, we_n, done_n, ncomp;
  logic err, done_seen, any_done;
  int   order [4];
  int   cyc   [4];

  initial begin
    rst = 1'b0;
    a_m0_req = 0; a_m0_we = 0; a_m0_addr = 0; a_m0_wdata = 0;
    a_m1_req = 0; a_m1_we = 0; a_m1_addr = 0; a_m1_wdata = 0;
    b_m0_req = 0; b_m0_we = 0; b_m0_addr = 0; b_m0_wdata = 0;
    b_m1_req = 0; b_m1_we = 0; b_m1_addr = 0; b_m1_wdata = 0;
    a_mem_rdata = 0; b_mem_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_mem_re", 32'(a_mem_re), 32'd0);
    chk("rst_mem_addr", a_mem_addr, 32'd0);
    chk("rst_m0_rdata", a_m0_rdata, 32'd0);
    chk("rst_stall", 32'(a_cpu_stall), 32'd0);
    rst = 1'b1;

    // Reset in the middle of an access aborts it with no done.
    a_m0_req = 1'b1; a_m0_addr = 32'h10;
    tick();
    chk("t1_re_pre", 32'(a_mem_re), 32'd1);
    #2 rst = 1'b0; a_m0_req = 1'b0;
    #1;
    chk("t1_re", 32'(a_mem_re), 32'd0);
    chk("t1_addr", a_mem_addr, 32'd0);
    chk("t1_stall", 32'(a_cpu_stall), 32'd0);
    chk("t1_done", 32'({a_m0_done, a_m1_done}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    any_done = 1'b0;
    repeat (4) begin tick(); any_done |= a_m0_done | a_m1_done; end
    chk("t1_no_done", 32'(any_done), 32'd0);

    // Both masters request continuously: alternate starting with M0, period 4 cycles.
    a_mem_rdata = 32'h0BADF00D;
    a_m0_req = 1'b1; a_m0_we = 1'b0; a_m0_addr = 32'h40;
    a_m1_req = 1'b1; a_m1_we = 1'b0; a_m1_addr = 32'h80;
    ncomp = 0;
    for (int i = 1; i <= 40 && ncomp < 4; i++) begin
      tick();
      if (a_m0_done && a_m1_done) chk("t3_both_done", 32'd1, 32'd0);
      if (a_m0_done || a_m1_done) begin
        order[ncomp] = a_m1_done ? 1 : 0;
        cyc[ncomp] = i;
        ncomp++;
      end
    end
    a_m0_req = 1'b0; a_m1_req = 1'b0;
    chk("t3_count", 32'(ncomp), 32'd4);
    chk("t3_first_lat", 32'(cyc[0]), 32'd3);
    for (int i = 0; i < 4; i++) chk("t3_order", 32'(order[i]), 32'(i % 2));
    for (int i = 0; i < 3; i++) chk("t3_gap", 32'(cyc[i+1] - cyc[i]), 32'd4);
    chk("t3_m0_rdata", a_m0_rdata, 32'h0BADF00D);
    chk("t3_m1_rdata", a_m1_rdata, 32'h0BADF00D);
    tick();

    // M0 read with one wait state.
    a_mem_rdata = 32'hDEADBEEF;
    a_m0_req = 1'b1; a_m0_we = 1'b0; a_m0_addr = 32'h100;
    #1 chk("t2_stall0", 32'(a_cpu_stall), 32'd1);
    tick();
    chk("t2_re1", 32'(a_mem_re), 32'd1);
    chk("t2_addr", a_mem_addr, 32'h100);
    chk("t2_done1", 32'(a_m0_done), 32'd0);
    tick();
    chk("t2_re2", 32'(a_mem_re), 32'd1);
    chk("t2_stall2", 32'(a_cpu_stall), 32'd1);
    chk("t2_done2", 32'(a_m0_done), 32'd0);
    tick();
    chk("t2_done3", 32'(a_m0_done), 32'd1);
    chk("t2_rdata", a_m0_rdata, 32'hDEADBEEF);
    chk("t2_re3", 32'(a_mem_re), 32'd0);
    chk("t2_stall3", 32'(a_cpu_stall), 32'd0);
    chk("t2_err", 32'(a_m0_err), 32'd0);
    chk("t2_m1_done", 32'(a_m1_done), 32'd0);
    a_m0_req = 1'b0;
    tick();
    chk("t2_done4", 32'(a_m0_done), 32'd0);

    // M1 write: no rdata is touched.
    a_mem_rdata = 32'h13572468;
    run_acc(1'b1, 1'b1, 32'h20, 32'h55AA55AA, ticks, re_n, we_n, err, done_seen);
    chk("t4_done", 32'(done_seen), 32'd1);
    chk("t4_lat", 32'(ticks), 32'd3);
    chk("t4_we_cyc", 32'(we_n), 32'd2);
    chk("t4_re_cyc", 32'(re_n), 32'd0);
    chk("t4_wdata", a_mem_wdata, 32'h55AA55AA);
    chk("t4_addr", a_mem_addr, 32'h20);
    chk("t4_err", 32'(err), 32'd0);
    chk("t4_m0_rdata", a_m0_rdata, 32'hDEADBEEF);
    chk("t4_m1_rdata", a_m1_rdata, 32'h0BADF00D);

    // Misaligned M0 read: no memory strobes, err with done, rdata kept.
    a_mem_rdata = 32'h12345678;
    run_acc(1'b0, 1'b0, 32'h102, 32'h0, ticks, re_n, we_n, err, done_seen);
    chk("t5_done", 32'(done_seen), 32'd1);
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_re_cyc", 32'(re_n), 32'd0);
    chk("t5_we_cyc", 32'(we_n), 32'd0);
    chk("t5_rdata", a_m0_rdata, 32'hDEADBEEF);
    chk("t5_err_clr", 32'(a_m0_err), 32'd0);

    // No wait states; M0 drops req one cycle into the access.
    b_mem_rdata = 32'hFEEDF00D;
    b_m0_req = 1'b1; b_m0_we = 1'b0; b_m0_addr = 32'h8;
    re_n = 0; done_n = 0;
    tick();
    re_n += int'(b_mem_re);
    b_m0_req = 1'b0;
    #1 chk("t6_stall", 32'(b_cpu_stall), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      re_n += int'(b_mem_re);
      done_n += int'(b_m0_done);
      if (b_m0_done) chk("t6_rdata", b_m0_rdata, 32'hFEEDF00D);
    end
    chk("t6_done_n", 32'(done_n), 32'd1);
    chk("t6_re_cyc", 32'(re_n), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
